// File: rtl/if_fetch_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [31:0] NOP_INSTR    = 32'b0;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEF_PC_STEP  = 4;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory handshake: one request outstanding, address held until ready.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage_pc_adder.sv
// Sequential-PC adder; wraps modulo 2^32.
module pc_adder
  import if_pkg::*;
#(
  parameter int unsigned PC_STEP = DEF_PC_STEP
) (
  input  logic [31:0] i_pc,
  output logic [31:0] o_sum
);

  assign o_sum = i_pc + PC_STEP[31:0];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a variable-latency
// handshake, handles EXE redirects and holds a fetched word across freezes.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int unsigned PC_STEP  = DEF_PC_STEP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               Branch_taken,
  input  logic [31:0]        BranchAddr,
  if_fetch_stage_if.master   imem,
  output logic [31:0]        PC,
  output logic [31:0]        Instruction
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_FETCH = FETCH;
  localparam logic [1:0] S_HOLD  = HOLD;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_pc_reg;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_redirect_pc;
  logic [31:0] w_redirect_nxt;
  logic [31:0] r_hold_instr;
  logic [31:0] w_hold_nxt;
  logic [31:0] w_pc_inc;
  logic [31:0] w_branch_addr;

  // Redirect targets are always word aligned.
  assign w_branch_addr  = BranchAddr & ~32'h3;
  assign imem.imem_addr = r_pc_reg;

  pc_adder #(.PC_STEP(PC_STEP)) u_pc_adder (
    .i_pc  (r_pc_reg),
    .o_sum (w_pc_inc)
  );

  // Next-state, next-PC and presented-output decode; redirect beats a response.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc_reg;
    w_redirect_nxt = r_redirect_pc;
    w_hold_nxt     = r_hold_instr;
    imem.imem_req  = 1'b0;
    PC             = 32'b0;
    Instruction    = NOP_INSTR;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem.imem_req = 1'b1;
        if (Branch_taken) begin
          if (imem.imem_ready) begin
            w_pc_nxt = w_branch_addr;
          end else begin
            // Request is still in flight: keep its address and drain it first.
            w_redirect_nxt = w_branch_addr;
            w_state_nxt    = S_DRAIN;
          end
        end else if (imem.imem_ready) begin
          Instruction = imem.imem_rdata;
          PC          = w_pc_inc;
          w_pc_nxt    = w_pc_inc;
          if (freeze) begin
            w_hold_nxt  = imem.imem_rdata;
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (Branch_taken) begin
          w_pc_nxt    = w_branch_addr;
          w_state_nxt = S_FETCH;
        end else begin
          Instruction = r_hold_instr;
          PC          = r_pc_reg;
          if (!freeze) begin
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        imem.imem_req = 1'b1;
        if (Branch_taken) begin
          w_redirect_nxt = w_branch_addr;
        end
        if (imem.imem_ready) begin
          w_pc_nxt    = Branch_taken ? w_branch_addr : r_redirect_pc;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and PC registers; reset withdraws any outstanding request at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc_reg      <= RESET_PC;
      r_redirect_pc <= 32'b0;
      r_hold_instr  <= 32'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc_reg      <= w_pc_nxt;
      r_redirect_pc <= w_redirect_nxt;
      r_hold_instr  <= w_hold_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed scenarios push expected
// {PC, Instruction} pairs; a monitor pops them whenever IF/ID would capture.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        Branch_taken;
  logic [31:0] BranchAddr;
  logic [31:0] PC;
  logic [31:0] Instruction;

  if_fetch_stage_if bus ();

  if_fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .Branch_taken (Branch_taken),
    .BranchAddr   (BranchAddr),
    .imem         (bus),
    .PC           (PC),
    .Instruction  (Instruction)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: word at address a is 32'hA000_0000 | a.
  // Latency lat: ready arrives in the lat-th cycle of a request (1 = zero wait).
  logic mem_en;
  logic force_rdy;
  int   lat;
  int   cnt;

  assign bus.imem_ready = (bus.imem_req && mem_en && (cnt == lat - 1)) || force_rdy;
  assign bus.imem_rdata = 32'hA000_0000 | bus.imem_addr;

  always @(posedge clk) begin
    if (rst || !bus.imem_req || bus.imem_ready) cnt <= 0;
    else                                        cnt <= cnt + 1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  // Monitor: a non-bubble output with freeze low is what IF/ID captures.
  always @(negedge clk) begin
    if (!rst && !freeze && (PC != 32'b0 || Instruction != 32'b0)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got PC=%h Instr=%h, expected bubble", PC, Instruction);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({PC, Instruction} !== mon_exp) begin
          n_fail++;
          $display("FAIL fetch_output: got PC=%h Instr=%h, expected PC=%h Instr=%h",
                   PC, Instruction, mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  task automatic do_reset();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    rst = 1'b1; Branch_taken = 1'b0; BranchAddr = 32'b0; freeze = 1'b0;
    mem_en = 1'b0; force_rdy = 1'b0; lat = 1;
    tick();
    #2;
    chk("rst_req",   {31'b0, bus.imem_req}, 32'd0);
    chk("rst_pc",    PC, 32'd0);
    chk("rst_instr", Instruction, 32'd0);
    chk("rst_addr",  bus.imem_addr, 32'h0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; freeze = 1'b0; Branch_taken = 1'b0; BranchAddr = 32'b0;
    mem_en = 1'b0; force_rdy = 1'b0; lat = 1;

    // Zero-wait memory: one instruction per cycle.
    do_reset();
    #2;
    chk("s1_idle_req", {31'b0, bus.imem_req}, 32'd0);
    chk("s1_idle_pc",  PC, 32'd0);
    mem_en = 1'b1;
    push(32'h4, 32'hA000_0000);
    push(32'h8, 32'hA000_0004);
    push(32'hC, 32'hA000_0008);
    tick();
    #2;
    chk("s1_c1_req",  {31'b0, bus.imem_req}, 32'd1);
    chk("s1_c1_addr", bus.imem_addr, 32'h0);
    tick(); tick();
    tick(); mem_en = 1'b0;
    #2;
    chk("s1_stall_addr", bus.imem_addr, 32'hC);

    // 3-cycle latency, freeze across the response for address 8.
    do_reset();
    lat = 3; mem_en = 1'b1;
    push(32'h4,  32'hA000_0000);
    push(32'h8,  32'hA000_0004);
    push(32'hC,  32'hA000_0008);
    push(32'h10, 32'hA000_000C);
    tick();
    #2;
    chk("s2_c1_pc",   PC, 32'd0);
    chk("s2_c1_addr", bus.imem_addr, 32'h0);
    tick();
    #2;
    chk("s2_c2_req",   {31'b0, bus.imem_req}, 32'd1);
    chk("s2_c2_addr",  bus.imem_addr, 32'h0);
    chk("s2_c2_instr", Instruction, 32'd0);
    tick();
    tick(); tick(); tick();
    tick(); tick();
    tick(); freeze = 1'b1;
    tick();
    #2;
    chk("s2_hold_req",   {31'b0, bus.imem_req}, 32'd0);
    chk("s2_hold_pc",    PC, 32'hC);
    chk("s2_hold_instr", Instruction, 32'hA000_0008);
    tick(); freeze = 1'b0;
    #2;
    chk("s2_release_pc", PC, 32'hC);
    tick();
    #2;
    chk("s2_next_req",  {31'b0, bus.imem_req}, 32'd1);
    chk("s2_next_addr", bus.imem_addr, 32'hC);
    tick(); tick();
    tick(); mem_en = 1'b0;

    // Branch while waiting: drain old request, last redirect wins, low bits masked.
    do_reset();
    lat = 3; mem_en = 1'b1;
    push(32'h4,  32'hA000_0000);
    push(32'h8,  32'hA000_0004);
    push(32'h44, 32'hA000_0040);
    tick(); tick(); tick(); tick(); tick(); tick(); tick();
    Branch_taken = 1'b1; BranchAddr = 32'h80;
    #2;
    chk("s3_br_pc",    PC, 32'd0);
    chk("s3_br_instr", Instruction, 32'd0);
    tick();
    BranchAddr = 32'h43;
    #2;
    chk("s3_drain_addr", bus.imem_addr, 32'h8);
    chk("s3_drain_req",  {31'b0, bus.imem_req}, 32'd1);
    tick();
    Branch_taken = 1'b0;
    #2;
    chk("s3_discard_pc",    PC, 32'd0);
    chk("s3_discard_instr", Instruction, 32'd0);
    chk("s3_discard_addr",  bus.imem_addr, 32'h8);
    tick();
    #2;
    chk("s3_redirect_addr", bus.imem_addr, 32'h40);
    tick(); tick();
    tick(); mem_en = 1'b0;

    // Branch with ready in the same cycle, then branch out of HOLD.
    do_reset();
    lat = 1; mem_en = 1'b1;
    push(32'h4,   32'hA000_0000);
    push(32'h104, 32'hA000_0100);
    tick();
    tick();
    Branch_taken = 1'b1; BranchAddr = 32'h100;
    #2;
    chk("s4_br_ready_pc",    PC, 32'd0);
    chk("s4_br_ready_instr", Instruction, 32'd0);
    tick();
    Branch_taken = 1'b0; freeze = 1'b1;
    #2;
    chk("s4_target_addr", bus.imem_addr, 32'h100);
    tick();
    Branch_taken = 1'b1; BranchAddr = 32'h100;
    #2;
    chk("s4_hold_br_pc",    PC, 32'd0);
    chk("s4_hold_br_instr", Instruction, 32'd0);
    chk("s4_hold_br_req",   {31'b0, bus.imem_req}, 32'd0);
    tick();
    Branch_taken = 1'b0; freeze = 1'b0;
    #2;
    chk("s4_refetch_addr", bus.imem_addr, 32'h100);
    tick(); mem_en = 1'b0;

    // Reset in DRAIN with a late ready pulse.
    do_reset();
    lat = 3; mem_en = 1'b1;
    tick();
    Branch_taken = 1'b1; BranchAddr = 32'h40;
    tick();
    Branch_taken = 1'b0;
    #2;
    chk("s5_drain_req", {31'b0, bus.imem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("s5_rst_req",   {31'b0, bus.imem_req}, 32'd0);
    chk("s5_rst_pc",    PC, 32'd0);
    chk("s5_rst_instr", Instruction, 32'd0);
    tick();
    rst = 1'b0; force_rdy = 1'b1;
    #2;
    chk("s5_late_req",   {31'b0, bus.imem_req}, 32'd0);
    chk("s5_late_pc",    PC, 32'd0);
    chk("s5_late_instr", Instruction, 32'd0);
    tick();
    force_rdy = 1'b0;
    #2;
    chk("s5_restart_req",  {31'b0, bus.imem_req}, 32'd1);
    chk("s5_restart_addr", bus.imem_addr, 32'h0);
    push(32'h4, 32'hA000_0000);
    tick(); tick();
    tick(); mem_en = 1'b0;

    // PC wrap at the top of the address space.
    do_reset();
    lat = 1; mem_en = 1'b1;
    tick();
    Branch_taken = 1'b1; BranchAddr = 32'hFFFF_FFFC;
    #2;
    chk("s6_br_pc", PC, 32'd0);
    push(32'h0, 32'hFFFF_FFFC);
    tick();
    Branch_taken = 1'b0;
    #2;
    chk("s6_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    tick(); mem_en = 1'b0;
    #2;
    chk("s6_wrap_addr", bus.imem_addr, 32'h0);

    tick();
    chk("final_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
